// File: rtl/waxwing_pkg.sv
// Shared definitions for the waxwing switch/LED peripheral: register map and edge-mode encodings.
package waxwing_pkg;

    typedef enum logic [1:0] {
        GPIO_STATE = 2'd0,
        GPIO_EDGE  = 2'd1,
        GPIO_LED   = 2'd2,
        GPIO_MASK  = 2'd3
    } gpio_reg_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Any mode outside the known encodings behaves as "both edges".
    function automatic logic edge_hit(input logic rise, input logic fall, input int mode);
        logic hit;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/waxwing_debounce.sv
// One switch channel: two-flop synchroniser, hold-time qualifier and single-cycle rise/fall pulses.
module waxwing_debounce
    import waxwing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          stable_r;
    logic          qualify_s;

    // Synchroniser: bring the asynchronous switch into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // The new level is accepted on the same edge the pulses fire, so the
    // top can set its flag on the cycle the stable level changes.
    always_comb begin
        qualify_s = (sync_r[1] != stable_r) && (cnt_r == CNT_LAST);
    end

    // Hold-time counter: any return to the stable level restarts qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
        end else if (sync_r[1] == stable_r) begin
            cnt_r <= {CW{1'b0}};
        end else if (qualify_s) begin
            stable_r <= sync_r[1];
            cnt_r    <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign stable = stable_r;
    assign rise   = qualify_s & sync_r[1];
    assign fall   = qualify_s & ~sync_r[1];

endmodule

// File: rtl/waxwing_gpio.sv
// Switch/LED peripheral for the waxwing CPU: debounced switch state, sticky maskable edge flags,
// LED register and a registered 4-entry bus read port.
module waxwing_gpio
    import waxwing_pkg::*;
#(
    parameter int SW_WIDTH        = 7,
    parameter int LED_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 2,
    parameter logic [LED_WIDTH-1:0] LED_RESET = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [SW_WIDTH-1:0]   Switch,
    output logic [LED_WIDTH-1:0]  LED,
    input  logic [1:0]            Addr,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Irq
);

    logic [SW_WIDTH-1:0]   stable_s;
    logic [SW_WIDTH-1:0]   rise_s;
    logic [SW_WIDTH-1:0]   fall_s;
    logic [SW_WIDTH-1:0]   set_s;
    logic [SW_WIDTH-1:0]   clr_s;
    logic [SW_WIDTH-1:0]   edge_r;
    logic [SW_WIDTH-1:0]   mask_r;
    logic [LED_WIDTH-1:0]  led_r;
    logic [DATA_WIDTH-1:0] rd_mux_s;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  irq_r;
    logic                  unused_wr_s;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_chan
        waxwing_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (Clk),
            .rst_n  (Rst_n),
            .raw    (Switch[i]),
            .stable (stable_s[i]),
            .rise   (rise_s[i]),
            .fall   (fall_s[i])
        );
        assign set_s[i] = edge_hit(rise_s[i], fall_s[i], EDGE_MODE);
    end

    // Write-one-to-clear mask for the edge flags.
    always_comb begin
        clr_s = {SW_WIDTH{1'b0}};
        if (WrEn && (gpio_reg_e'(Addr) == GPIO_EDGE)) begin
            clr_s = WrData[SW_WIDTH-1:0];
        end else begin
            clr_s = {SW_WIDTH{1'b0}};
        end
    end

    // Register file; a new edge overrides a clear of the same bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            edge_r <= {SW_WIDTH{1'b0}};
            mask_r <= {SW_WIDTH{1'b0}};
            led_r  <= LED_RESET;
            irq_r  <= 1'b0;
        end else begin
            edge_r <= (edge_r & ~clr_s) | set_s;
            irq_r  <= |(edge_r & mask_r);
            if (WrEn && (gpio_reg_e'(Addr) == GPIO_MASK)) begin
                mask_r <= WrData[SW_WIDTH-1:0];
            end
            if (WrEn && (gpio_reg_e'(Addr) == GPIO_LED)) begin
                led_r <= WrData[LED_WIDTH-1:0];
            end
        end
    end

    // Read mux: narrow fields are zero-extended to the bus width.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        case (gpio_reg_e'(Addr))
            GPIO_STATE: rd_mux_s = DATA_WIDTH'(stable_s);
            GPIO_EDGE:  rd_mux_s = DATA_WIDTH'(edge_r);
            GPIO_LED:   rd_mux_s = DATA_WIDTH'(led_r);
            GPIO_MASK:  rd_mux_s = DATA_WIDTH'(mask_r);
            default:    rd_mux_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Read data register samples pre-write contents and holds between reads.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (RdEn) begin
            rd_data_r <= rd_mux_s;
        end
    end

    assign unused_wr_s = ^WrData;
    assign LED         = led_r;
    assign RdData      = rd_data_r;
    assign Irq         = irq_r;

endmodule

// File: tb/tb_waxwing_gpio.sv
// Directed self-checking bench for waxwing_gpio with DEBOUNCE_CYCLES=4, EDGE_MODE=both, LED_RESET=8'hA5.
module tb_waxwing_gpio;

    logic       clk;
    logic       rst_n;
    logic [6:0] sw;
    logic [7:0] led;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       irq;
    logic [7:0] rd;
    int checks;
    int errors;

    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_EDGE  = 2'd1;
    localparam logic [1:0] A_LED   = 2'd2;
    localparam logic [1:0] A_MASK  = 2'd3;

    waxwing_gpio #(
        .SW_WIDTH(7), .LED_WIDTH(8), .DATA_WIDTH(8),
        .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .LED_RESET(8'hA5)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Switch(sw), .LED(led), .Addr(addr),
        .WrEn(wr_en), .RdEn(rd_en), .WrData(wr_data), .RdData(rd_data), .Irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sw = 7'h00; addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        // Reset
        tick(3);
        check("rst_led", 16'(led), 16'h00A5);
        check("rst_rddata", 16'(rd_data), 16'h0000);
        check("rst_irq", 16'(irq), 16'h0000);
        rst_n = 1'b1;
        do_read(A_STATE, rd); check("rst_state", 16'(rd), 16'h0000);

        // Clean step: stable changes on the 6th edge counting the sampling edge
        sw = 7'h05;
        tick(5);
        do_read(A_STATE, rd); check("step_state_early", 16'(rd), 16'h0000);
        do_read(A_STATE, rd); check("step_state", 16'(rd), 16'h0005);
        do_read(A_EDGE, rd);  check("step_edge", 16'(rd), 16'h0005);
        check("step_irq_masked", 16'(irq), 16'h0000);

        // Falling edges and selective W1C
        sw = 7'h00;
        tick(8);
        do_read(A_STATE, rd); check("fall_state", 16'(rd), 16'h0000);
        do_read(A_EDGE, rd);  check("fall_edge", 16'(rd), 16'h0005);
        do_write(A_EDGE, 8'h01);
        do_read(A_EDGE, rd);  check("w1c_partial", 16'(rd), 16'h0004);
        do_write(A_EDGE, 8'h7F);
        do_read(A_EDGE, rd);  check("w1c_all", 16'(rd), 16'h0000);

        // Bounce on bit0: each level held only 2 cycles
        for (int i = 0; i < 10; i++) begin
            sw[0] = ~sw[0];
            tick(2);
        end
        sw = 7'h00;
        tick(8);
        do_read(A_STATE, rd); check("bounce_state", 16'(rd), 16'h0000);
        do_read(A_EDGE, rd);  check("bounce_edge", 16'(rd), 16'h0000);

        // Irq and W1C
        do_write(A_MASK, 8'h01);
        sw = 7'h01;
        tick(6);
        check("irq_before", 16'(irq), 16'h0000);
        tick(1);
        check("irq_set", 16'(irq), 16'h0001);
        do_write(A_EDGE, 8'h01);
        check("irq_hold", 16'(irq), 16'h0001);
        tick(1);
        check("irq_clear", 16'(irq), 16'h0000);

        // Mask blocks Irq; enabling it later raises Irq from the pending flag
        do_write(A_MASK, 8'h00);
        sw = 7'h00;
        tick(10);
        check("irq_blocked", 16'(irq), 16'h0000);
        do_read(A_EDGE, rd); check("masked_edge", 16'(rd), 16'h0001);
        do_write(A_MASK, 8'h01);
        tick(1);
        check("irq_unmask", 16'(irq), 16'h0001);
        do_write(A_MASK, 8'h00);
        tick(1);
        check("irq_remask", 16'(irq), 16'h0000);
        do_write(A_EDGE, 8'h7F);

        // Collision: clear bit2 on the edge it qualifies
        sw = 7'h04;
        tick(5);
        do_write(A_EDGE, 8'h04);
        do_read(A_EDGE, rd);  check("collide_edge", 16'(rd), 16'h0004);
        do_read(A_STATE, rd); check("collide_state", 16'(rd), 16'h0004);
        do_write(A_EDGE, 8'h04);
        do_read(A_EDGE, rd);  check("collide_clear", 16'(rd), 16'h0000);

        // LED register and bus corner cases
        do_write(A_LED, 8'h3C);
        check("led_write", 16'(led), 16'h003C);
        do_read(A_LED, rd); check("led_read", 16'(rd), 16'h003C);
        addr = A_LED; wr_data = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
        tick(1);
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_same_read", 16'(rd_data), 16'h003C);
        check("rw_same_led", 16'(led), 16'h005A);
        tick(2);
        check("rddata_hold", 16'(rd_data), 16'h003C);
        do_write(A_STATE, 8'hFF);
        do_read(A_STATE, rd); check("state_ro", 16'(rd), 16'h0004);
        do_write(A_MASK, 8'hFF);
        do_read(A_MASK, rd);  check("mask_width", 16'(rd), 16'h007F);
        do_write(A_MASK, 8'h00);

        // Reset mid-debounce: input re-qualified from scratch
        sw = 7'h44;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_led", 16'(led), 16'h00A5);
        check("mid_rst_irq", 16'(irq), 16'h0000);
        rst_n = 1'b1;
        do_read(A_STATE, rd); check("mid_rst_state", 16'(rd), 16'h0000);
        do_read(A_EDGE, rd);  check("mid_rst_edge", 16'(rd), 16'h0000);
        tick(8);
        do_read(A_STATE, rd); check("requal_state", 16'(rd), 16'h0044);
        do_read(A_EDGE, rd);  check("requal_edge", 16'(rd), 16'h0044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
